branch_resolver: RTL

//  Resolution side of the BTB: tracks every fetch-stage prediction in an in-order queue,

---
 rtl/branch_resolver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Resolution side of the BTB: in-order queue of fetch predictions, checked against the
// EX outcome to produce misprediction/redirect, the BTB write and sequencing diagnostics.
module branch_resolver #(
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  input  logic                  fetch_pred_taken,
  input  logic [31:0]           fetch_pred_target,
  output logic                  fetch_ready,
  input  logic                  ex_valid,
  input  logic [31:0]           ex_pc,
  input  logic                  ex_is_branch,
  input  logic                  ex_taken,
  input  logic [31:0]           ex_target,
  output logic                  misprediction,
  output logic [31:0]           redirect_pc,
  output logic                  btb_we,
  output logic [INDEX_BITS-1:0] btb_windex,
  output logic [31:0]           btb_wdata,
  output logic                  seq_error,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [31:0]      SAT_MAX    = 32'hFFFF_FFFF;

  logic [31:0]      pc_mem_r  [DEPTH];
  logic             pt_mem_r  [DEPTH];
  logic [31:0]      tgt_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic [31:0] head_pc_s;
  logic        head_pt_s;
  logic [31:0] head_tgt_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_s;
  logic [31:0] pred_next_s;
  logic [31:0] act_next_s;
  logic        mis_s;
  logic        seq_err_s;

  assign fetch_ready = (count_r != FULL_COUNT);

  // Resolve the head entry against the EX outcome and decide push/pop for this cycle.
  always_comb begin
    head_pc_s   = pc_mem_r[head_r];
    head_pt_s   = pt_mem_r[head_r];
    head_tgt_s  = tgt_mem_r[head_r];
    empty_s     = (count_r == CNT_ZERO);
    pop_s       = ex_valid && !empty_s;
    pred_next_s = head_pt_s ? head_tgt_s : (head_pc_s + 32'd4);
    act_next_s  = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + 32'd4);
    mis_s       = pop_s && (pred_next_s != act_next_s);
    seq_err_s   = ex_valid && (empty_s || (ex_pc != head_pc_s));
    // Fetches during a redirect, or alongside a flushing pop, are wrong-path.
    push_s      = fetch_valid && fetch_ready && !misprediction && !mis_s;
  end

  // Queue pointers and occupancy; a mispredicting pop empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (mis_s) begin
      head_r  <= tail_r;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_ONE;
      if (pop_s)  head_r <= head_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Prediction storage; contents are don't-care while their slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[tail_r]  <= fetch_pc;
      pt_mem_r[tail_r]  <= fetch_pred_taken;
      tgt_mem_r[tail_r] <= fetch_pred_target;
    end
  end

  // Registered resolution outputs, pulses and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      misprediction    <= 1'b0;
      btb_we           <= 1'b0;
      seq_error        <= 1'b0;
      redirect_pc      <= 32'd0;
      btb_windex       <= {INDEX_BITS{1'b0}};
      btb_wdata        <= 32'd0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      misprediction <= mis_s;
      btb_we        <= mis_s;
      seq_error     <= seq_err_s;
      if (mis_s) begin
        redirect_pc <= act_next_s;
        btb_windex  <= ex_pc[INDEX_BITS-1:0];
        btb_wdata   <= act_next_s;
      end
      if (pop_s && ex_is_branch && (branch_count != SAT_MAX))
        branch_count <= branch_count + 32'd1;
      if (mis_s && (mispredict_count != SAT_MAX))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule
